// File: rtl/bp_skid_pipe_if.sv
// rtl/bp_skid_pipe_if.sv - handshake, flush and status bundle for bp_skid_pipe
interface bp_skid_pipe_if #(
  parameter int DATAW = 8,
  parameter int PIPES = 2,
  parameter int CNTW  = 16
);
  localparam int OCCW = (PIPES == 0) ? 1 : $clog2(2 * PIPES + 1);

  logic             flush_i;
  logic [DATAW-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic [DATAW-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic [OCCW-1:0]  occupancy_o;
  logic [CNTW-1:0]  stall_cnt_o;

  modport master (
    output flush_i, data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, occupancy_o, stall_cnt_o
  );

  modport slave (
    input  flush_i, data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, occupancy_o, stall_cnt_o
  );
endinterface

// File: rtl/bp_skid_pipe.sv
// rtl/bp_skid_pipe.sv - chain of two-entry skid stages; optional stall counter under BP_SKID_PIPE_PERF_EN
module bp_skid_pipe #(
  parameter int DATAW = 8,
  parameter int PIPES = 2,
  parameter int CNTW  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bp_skid_pipe_if.slave bus
);
  localparam int OCCW = (PIPES == 0) ? 1 : $clog2(2 * PIPES + 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  generate
    if (PIPES == 0) begin : g_pass
      assign bus.data_o      = bus.data_i;
      assign bus.valid_o     = bus.valid_i;
      assign bus.ready_o     = bus.ready_i;
      assign bus.occupancy_o = '0;
    end else begin : g_pipe
      stage_state_t     state_q [PIPES];
      stage_state_t     state_d [PIPES];
      logic [DATAW-1:0] main_q  [PIPES];
      logic [DATAW-1:0] main_d  [PIPES];
      logic [DATAW-1:0] skid_q  [PIPES];
      logic [DATAW-1:0] skid_d  [PIPES];
      logic [DATAW-1:0] up_data [PIPES];
      logic [PIPES-1:0] stg_valid;
      logic [PIPES-1:0] stg_ready;
      logic [PIPES-1:0] up_valid;
      logic [PIPES-1:0] dn_ready;
      logic [PIPES-1:0] in_xfer;
      logic [PIPES-1:0] out_xfer;
      logic [OCCW-1:0]  occ_q;
      logic [OCCW-1:0]  occ_d;

      // Each stage's ready is decoded from its own state only, so the
      // ready chain is broken by a flop at every stage.
      for (genvar i = 0; i < PIPES; i++) begin : g_stg
        assign stg_valid[i] = (state_q[i] != ST_EMPTY);
        assign stg_ready[i] = (state_q[i] != ST_FULL);

        if (i == 0) begin : g_head
          assign up_valid[i] = bus.valid_i;
          assign up_data[i]  = bus.data_i;
        end else begin : g_body
          assign up_valid[i] = stg_valid[i-1];
          assign up_data[i]  = main_q[i-1];
        end

        if (i == PIPES - 1) begin : g_tail
          assign dn_ready[i] = bus.ready_i;
        end else begin : g_inner
          assign dn_ready[i] = stg_ready[i+1];
        end

        assign in_xfer[i]  = up_valid[i] && stg_ready[i];
        assign out_xfer[i] = stg_valid[i] && dn_ready[i];
      end

      // Per-stage next state: main holds the oldest word, skid the younger one.
      always_comb begin
        for (int i = 0; i < PIPES; i++) begin
          state_d[i] = state_q[i];
          main_d[i]  = main_q[i];
          skid_d[i]  = skid_q[i];
          case (state_q[i])
            ST_EMPTY: begin
              if (in_xfer[i]) begin
                main_d[i]  = up_data[i];
                state_d[i] = ST_BUSY;
              end
            end
            ST_BUSY: begin
              if (in_xfer[i] && out_xfer[i]) begin
                main_d[i] = up_data[i];
              end else if (in_xfer[i]) begin
                skid_d[i]  = up_data[i];
                state_d[i] = ST_FULL;
              end else if (out_xfer[i]) begin
                state_d[i] = ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (out_xfer[i]) begin
                main_d[i]  = skid_q[i];
                state_d[i] = ST_BUSY;
              end
            end
            default: state_d[i] = ST_EMPTY;
          endcase
          // Flush only invalidates; payload registers keep their contents.
          if (bus.flush_i) begin
            state_d[i] = ST_EMPTY;
            main_d[i]  = main_q[i];
            skid_d[i]  = skid_q[i];
          end
        end
      end

      // Occupancy follows the end-to-end transfers; flush empties it.
      always_comb begin
        occ_d = occ_q;
        if (bus.flush_i) begin
          occ_d = '0;
        end else if (in_xfer[0] && !out_xfer[PIPES-1]) begin
          occ_d = occ_q + OCCW'(1);
        end else if (!in_xfer[0] && out_xfer[PIPES-1]) begin
          occ_d = occ_q - OCCW'(1);
        end
      end

      // State, payload and occupancy registers.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < PIPES; i++) begin
            state_q[i] <= ST_EMPTY;
            main_q[i]  <= '0;
            skid_q[i]  <= '0;
          end
          occ_q <= '0;
        end else begin
          for (int i = 0; i < PIPES; i++) begin
            state_q[i] <= state_d[i];
            main_q[i]  <= main_d[i];
            skid_q[i]  <= skid_d[i];
          end
          occ_q <= occ_d;
        end
      end

      assign bus.ready_o     = stg_ready[0];
      assign bus.valid_o     = stg_valid[PIPES-1];
      assign bus.data_o      = main_q[PIPES-1];
      assign bus.occupancy_o = occ_q;
    end
  endgenerate

`ifdef BP_SKID_PIPE_PERF_EN
  logic [CNTW-1:0] stall_q;

  // Saturating count of cycles where output is offered but not taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (bus.valid_o && !bus.ready_i && (stall_q != {CNTW{1'b1}})) begin
      stall_q <= stall_q + CNTW'(1);
    end
  end

  assign bus.stall_cnt_o = stall_q;
`else
  assign bus.stall_cnt_o = {CNTW{1'b0}};
`endif
endmodule

// File: tb/tb_bp_skid_pipe.sv
// tb/tb_bp_skid_pipe.sv - directed self-checking bench for bp_skid_pipe
module tb_bp_skid_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  bp_skid_pipe_if #(.DATAW(8), .PIPES(3), .CNTW(16)) b3();
  bp_skid_pipe_if #(.DATAW(8), .PIPES(2), .CNTW(2))  b2();
  bp_skid_pipe_if #(.DATAW(8), .PIPES(0), .CNTW(16)) b0();

  bp_skid_pipe #(.DATAW(8), .PIPES(3), .CNTW(16)) u_p3 (.clk_i(clk), .rst_i(rst), .bus(b3.slave));
  bp_skid_pipe #(.DATAW(8), .PIPES(2), .CNTW(2))  u_p2 (.clk_i(clk), .rst_i(rst), .bus(b2.slave));
  bp_skid_pipe #(.DATAW(8), .PIPES(0), .CNTW(16)) u_p0 (.clk_i(clk), .rst_i(rst), .bus(b0.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nin, nout, first_v, gaps, ready_low, cnt_model, sent, recv, stale, perf_on;
    int perf_exp[6];
    perf_exp = '{1, 2, 3, 3, 3, 3};
`ifdef BP_SKID_PIPE_PERF_EN
    perf_on = 1;
`else
    perf_on = 0;
`endif
    b3.flush_i = 0; b3.data_i = 0; b3.valid_i = 0; b3.ready_i = 0;
    b2.flush_i = 0; b2.data_i = 0; b2.valid_i = 0; b2.ready_i = 0;
    b0.flush_i = 0; b0.data_i = 0; b0.valid_i = 0; b0.ready_i = 0;

    rst = 1'b1;
    step();
    step();
    check("rst_valid3", b3.valid_o, 0);
    check("rst_data3", b3.data_o, 0);
    check("rst_ready3", b3.ready_o, 1);
    check("rst_occ3", b3.occupancy_o, 0);
    check("rst_stall3", b3.stall_cnt_o, 0);
    check("rst_valid2", b2.valid_o, 0);
    check("rst_ready2", b2.ready_o, 1);
    check("rst_occ2", b2.occupancy_o, 0);
    rst = 1'b0;

    // streaming through three stages with the consumer always ready
    nin = 0; nout = 0; first_v = -1; gaps = 0; ready_low = 0;
    b3.ready_i = 1;
    for (int t = 0; t < 24; t++) begin
      if (!b3.ready_o) ready_low++;
      if (b3.valid_o) begin
        if (first_v < 0) first_v = t;
        check("stream_data", b3.data_o, nout);
        nout++;
      end else if (first_v >= 0 && nout < 16) begin
        gaps++;
      end
      if (nin < 16) begin
        b3.valid_i = 1;
        b3.data_i  = 8'(nin);
        nin++;
      end else begin
        b3.valid_i = 0;
      end
      step();
    end
    check("stream_first_lat", first_v, 3);
    check("stream_count", nout, 16);
    check("stream_gaps", gaps, 0);
    check("stream_ready_low", ready_low, 0);

    // full backpressure fills exactly 2*PIPES entries
    nin = 0;
    b2.ready_i = 0;
    for (int t = 0; t < 8; t++) begin
      b2.valid_i = 1;
      b2.data_i  = 8'(nin);
      if (b2.ready_o) nin++;
      step();
    end
    check("bp_accepts", nin, 4);
    check("bp_ready_o", b2.ready_o, 0);
    check("bp_occ", b2.occupancy_o, 4);
    b2.valid_i = 0;
    b2.ready_i = 1;
    for (int t = 0; t < 4; t++) begin
      check("bp_drain_valid", b2.valid_o, 1);
      check("bp_drain_data", b2.data_o, t);
      step();
    end
    check("bp_drain_empty", b2.valid_o, 0);
    check("bp_drain_occ", b2.occupancy_o, 0);

    // random consumer stalls against a scoreboard and an occupancy model
    cnt_model = 0; sent = 0; recv = 0;
    for (int t = 0; t < 4000 && recv < 1000; t++) begin
      check("rnd_occ", b2.occupancy_o, cnt_model);
      b2.ready_i = ($urandom_range(0, 99) >= 30);
      b2.valid_i = (sent < 1000);
      b2.data_i  = 8'(sent * 7 + 3);
      if (b2.valid_o && b2.ready_i) begin
        if (sb.size() == 0) check("rnd_spurious", 1, 0);
        else check("rnd_data", b2.data_o, sb.pop_front());
        recv++;
        cnt_model--;
      end
      if (b2.valid_i && b2.ready_o) begin
        sb.push_back(b2.data_i);
        sent++;
        cnt_model++;
      end
      step();
    end
    check("rnd_recv", recv, 1000);
    check("rnd_left", sb.size(), 0);
    check("rnd_occ_end", b2.occupancy_o, 0);
    b2.valid_i = 0;
    b2.ready_i = 0;
    step();

    // flush together with an output transfer and a discarded input
    for (int t = 0; t < 3; t++) begin
      b2.valid_i = 1;
      b2.data_i  = 8'(8'hA0 + t);
      step();
    end
    b2.valid_i = 0;
    check("fl_occ3", b2.occupancy_o, 3);
    b2.valid_i = 1;
    b2.data_i  = 8'h77;
    b2.ready_i = 1;
    b2.flush_i = 1;
    check("fl_deliver_valid", b2.valid_o, 1);
    check("fl_deliver_data", b2.data_o, 8'hA0);
    step();
    b2.flush_i = 0;
    b2.valid_i = 0;
    check("fl_valid0", b2.valid_o, 0);
    check("fl_occ0", b2.occupancy_o, 0);
    check("fl_ready1", b2.ready_o, 1);
    b2.valid_i = 1;
    b2.data_i  = 8'h55;
    step();
    b2.valid_i = 0;
    check("fl_lat_early", b2.valid_o, 0);
    step();
    check("fl_new_valid", b2.valid_o, 1);
    check("fl_new_data", b2.data_o, 8'h55);
    step();
    check("fl_new_occ", b2.occupancy_o, 0);

    // reset while four words are held
    b2.ready_i = 0;
    for (int t = 0; t < 4; t++) begin
      b2.valid_i = 1;
      b2.data_i  = 8'(8'hC0 + t);
      step();
    end
    check("mr_occ4", b2.occupancy_o, 4);
    rst = 1'b1;
    b2.data_i = 8'hEE;
    step();
    rst = 1'b0;
    b2.valid_i = 0;
    check("mr_valid", b2.valid_o, 0);
    check("mr_data", b2.data_o, 0);
    check("mr_ready", b2.ready_o, 1);
    check("mr_occ", b2.occupancy_o, 0);
    check("mr_stall", b2.stall_cnt_o, 0);
    stale = 0;
    b2.ready_i = 1;
    for (int t = 0; t < 5; t++) begin
      if (b2.valid_o) stale++;
      step();
    end
    check("mr_stale", stale, 0);
    b2.valid_i = 1;
    b2.data_i  = 8'h33;
    step();
    b2.valid_i = 0;
    step();
    check("mr_new_valid", b2.valid_o, 1);
    check("mr_new_data", b2.data_o, 8'h33);
    step();

    // stall counter saturation and flush persistence
    rst = 1'b1;
    step();
    rst = 1'b0;
    b2.ready_i = 0;
    b2.valid_i = 1;
    b2.data_i  = 8'h11;
    step();
    b2.valid_i = 0;
    step();
    check("perf_valid", b2.valid_o, 1);
    check("perf_start", b2.stall_cnt_o, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("perf_cnt", b2.stall_cnt_o, perf_on ? perf_exp[k] : 0);
    end
    b2.flush_i = 1;
    step();
    b2.flush_i = 0;
    check("perf_after_flush", b2.stall_cnt_o, perf_on ? 3 : 0);
    check("perf_flush_valid", b2.valid_o, 0);

    // zero-stage build is a wire
    b0.data_i  = 8'h5A;
    b0.valid_i = 1;
    b0.ready_i = 0;
    #1;
    check("p0_data", b0.data_o, 8'h5A);
    check("p0_valid", b0.valid_o, 1);
    check("p0_ready0", b0.ready_o, 0);
    check("p0_occ", b0.occupancy_o, 0);
    b0.ready_i = 1;
    b0.flush_i = 1;
    #1;
    check("p0_ready1", b0.ready_o, 1);
    check("p0_flush_valid", b0.valid_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_skid_pipe.md
# bp_skid_pipe

Multi-stage valid/ready pipeline where every stage is a two-entry skid buffer. It sustains one transfer per cycle under backpressure and has no combinational path from `ready_i` to `ready_o`. It is the drop-in successor to the single-register backpressured pipe for long datapaths, where the ready chain would otherwise limit timing. It adds a synchronous flush, an occupancy output, and an optional stall counter.

## Interface
Parameters:
- `DATAW`, 8: payload width in bits (≥1).
- `PIPES`, 2: number of skid stages; 0 = pass-through.
- `CNTW`, 16: stall counter width (≥1); used only with `BP_SKID_PIPE_PERF_EN`.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `flush_i` input 1: synchronous invalidate of all stored entries.
- `data_i` input DATAW: upstream payload.
- `valid_i` input 1: upstream valid.
- `ready_o` output 1: upstream ready. Decoded from stage-0 state only.
- `data_o` output DATAW: downstream payload, taken from the last stage's main register.
- `valid_o` output 1: downstream valid.
- `ready_i` input 1: downstream ready.
- `occupancy_o` output max(1,$clog2(2*PIPES+1)): number of valid entries held.
- `stall_cnt_o` output CNTW: cycles with `valid_o && !ready_i`, saturating.

## Operation
- Transfers:
  - Input transfer = `valid_i && ready_o`.
  - Output transfer = `valid_o && ready_i`.
  - Payload order is preserved; nothing is dropped or duplicated except by flush.
- Each stage has a main register, a skid register and a 2-bit state.
- States and transitions (in = upstream transfer into the stage, out = downstream transfer from the stage):
  - EMPTY: stage ready=1, valid=0.
    - in: main←in, go to BUSY.
  - BUSY: ready=1, valid=1.
    - in && out: main←in, stay in BUSY.
    - in only: skid←in, go to FULL.
    - out only: go to EMPTY.
  - FULL: ready=0, valid=1.
    - out: main←skid, go to BUSY.
- Stage i's downstream ready is stage i+1's ready; the last stage uses `ready_i`.
- Stage ready is a pure decode of its own state flops (ready = state≠FULL).
- Capacity is 2·PIPES entries.
- Occupancy register:
  - Normal cycle: += input transfer, −= output transfer.
  - Flush cycle: forced to 0.
  - Range is 0..2·PIPES; it never wraps.
- Flush (`flush_i`=1 and `rst_i`=0):
  - All stages go to EMPTY on the next edge; data registers are untouched.
  - An output transfer in the flush cycle counts as delivered.
  - An input transfer in the flush cycle is discarded.
- Reset (`rst_i`=1):
  - Overrides flush.
  - All stages go to EMPTY; main, skid and occupancy are cleared to 0; the stall counter is cleared.
  - Handshakes during reset cycles are ignored.
  - Asserting reset mid-stream discards all content.
- PIPES=0:
  - `data_o`=`data_i`, `valid_o`=`valid_i`, `ready_o`=`ready_i`.
  - `occupancy_o`=0; flush has no effect.

## Timing
- Values after the first edge with `rst_i`=1: `valid_o`=0, `data_o`=0, `ready_o`=1, `occupancy_o`=0, `stall_cnt_o`=0.
- Latency:
  - Input transfer at edge N appears on `data_o`/`valid_o` after edge N+PIPES−1, i.e. PIPES cycles after acceptance, provided no stage is stalled.
  - Each stall cycle adds one cycle.
- Throughput: 1 transfer/cycle sustained while `ready_i`=1.
- Backpressure propagation:
  - `ready_i` dropping at cycle N deasserts `ready_o` no earlier than N+PIPES.
  - Skid entries absorb transfers in flight.
- `ready_o`, `valid_o` and `data_o` depend only on flops (PIPES≥1).
- Simultaneous flush and output transfer: the transfer completes; afterwards `valid_o`=0 and `occupancy_o`=0.

## Configuration
- Macro `BP_SKID_PIPE_PERF_EN`.
- Defined:
  - `stall_cnt_o` counts each cycle with `valid_o && !ready_i`.
  - It saturates at 2^CNTW−1.
  - It is cleared only by `rst_i`, not by flush.
- Undefined: no counter logic is built and `stall_cnt_o` is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Streaming: PIPES=3, DATAW=8, 16 back-to-back words 0x00..0x0F, `ready_i`=1. Required:
  - First `valid_o` 3 cycles after the first acceptance.
  - 16 consecutive output transfers in order.
  - `ready_o` never low.
- Full backpressure: PIPES=2, `ready_i`=0, `valid_i`=1 continuously. Required:
  - Exactly 4 input transfers, then `ready_o`=0.
  - `occupancy_o`=4.
  - Raising `ready_i` drains the 4 words in order at 1 per cycle.
- Random ready: 30% random `ready_i` drops, 1000 words. Required:
  - Scoreboard match.
  - `occupancy_o` equals the model count every cycle.
- Flush: PIPES=2 holding 3 words, `flush_i` pulsed together with an output transfer. Required:
  - That word is delivered.
  - Next cycle `valid_o`=0, `occupancy_o`=0, `ready_o`=1.
  - New words flow with PIPES latency.
- Reset mid-operation: `rst_i` pulsed while 4 words are held. Required: reset values on the next cycle; no stale word ever appears on `data_o`.
- Perf counter (macro defined, CNTW=2): hold `valid_o`=1 with `ready_i`=0 for 6 cycles. Required:
  - `stall_cnt_o` = 1,2,3,3,3,3.
  - The value is not cleared by flush.
  - With the macro undefined it stays at 0.
